// File: rtl/multiplexer_pkg.sv
// Shared constants, state type and pointer helper for the 4-to-1 arbitrating multiplexer.
package multiplexer_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } mux_state_e;

    // Round-robin successor of a granted index, wrapping at NUM_CH.
    function automatic logic [SEL_W-1:0] next_pointer(input logic [SEL_W-1:0] idx);
        return idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/round_robin_arbiter_4.sv
// Four-way grant logic. MULTIPLEXER_ROUND_ROBIN_EN selects a rotating search from
// 'pointer'; otherwise the lowest-index request wins and 'pointer' is ignored.
module round_robin_arbiter_4
    import multiplexer_pkg::*;
(
    input  logic [NUM_CH-1:0] request,
    input  logic [SEL_W-1:0]  pointer,
    input  logic              enable,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  index
);

    logic [SEL_W-1:0] base_s;
    logic [SEL_W-1:0] cand_s;
    logic             found_s;

`ifdef MULTIPLEXER_ROUND_ROBIN_EN
    assign base_s = pointer;
`else
    logic pointer_unused_s;
    assign base_s           = {SEL_W{1'b0}};
    assign pointer_unused_s = ^pointer;
`endif

    // Ascending search from base_s, wrapping modulo NUM_CH; first hit wins.
    always_comb begin
        grant   = {NUM_CH{1'b0}};
        index   = {SEL_W{1'b0}};
        found_s = 1'b0;
        cand_s  = base_s;
        for (int k = 0; k < NUM_CH; k++) begin
            cand_s = base_s + SEL_W'(k);
            if (enable && !found_s && request[cand_s]) begin
                grant[cand_s] = 1'b1;
                index         = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/multiplexer_4_to_1_arbiter.sv
// Four valid/ready channels merged into one registered output stage.
// MULTIPLEXER_ROUND_ROBIN_EN enables round-robin arbitration (fixed priority otherwise).
module multiplexer_4_to_1_arbiter
    import multiplexer_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        select_lines
);

    mux_state_e        state_r;
    logic [WIDTH-1:0]  out_data_r;
    logic [SEL_W-1:0]  select_r;
    logic [SEL_W-1:0]  pointer_s;
    logic              load_en_s;
    logic              arb_enable_s;
    logic [NUM_CH-1:0] grant_s;
    logic [SEL_W-1:0]  grant_idx_s;
    logic              any_grant_s;

    // Gating with rst_n keeps in_ready low for the whole time reset is held.
    assign load_en_s    = (state_r == ST_EMPTY) || out_ready;
    assign arb_enable_s = load_en_s && rst_n;
    assign any_grant_s  = |grant_s;

    round_robin_arbiter_4 u_arbiter (
        .request (in_valid),
        .pointer (pointer_s),
        .enable  (arb_enable_s),
        .grant   (grant_s),
        .index   (grant_idx_s)
    );

`ifdef MULTIPLEXER_ROUND_ROBIN_EN
    logic [SEL_W-1:0] pointer_r;

    // Priority pointer moves past the channel just granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pointer_r <= {SEL_W{1'b0}};
        end else if (any_grant_s) begin
            pointer_r <= next_pointer(grant_idx_s);
        end
    end

    assign pointer_s = pointer_r;
`else
    assign pointer_s = {SEL_W{1'b0}};
`endif

    // Output stage: load on grant, drain when consumed, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_EMPTY;
            out_data_r <= {WIDTH{1'b0}};
            select_r   <= {SEL_W{1'b0}};
        end else if (load_en_s) begin
            if (any_grant_s) begin
                state_r    <= ST_FULL;
                out_data_r <= in_data[grant_idx_s*WIDTH +: WIDTH];
                select_r   <= grant_idx_s;
            end else begin
                state_r    <= ST_EMPTY;
            end
        end
    end

    assign in_ready     = grant_s;
    assign out_valid    = (state_r == ST_FULL);
    assign out_data     = out_data_r;
    assign select_lines = select_r;

endmodule

// File: tb/tb_multiplexer_4_to_1_arbiter.sv
// Directed and scoreboard checks for multiplexer_4_to_1_arbiter; follows
// MULTIPLEXER_ROUND_ROBIN_EN to pick round-robin or fixed-priority expectations.
module tb_multiplexer_4_to_1_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [1:0]  select_lines;

    int n_cmp;
    int n_err;

    multiplexer_4_to_1_arbiter #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .select_lines (select_lines)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        in_data   = 32'h0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got %h want 00", out_data); end
        n_cmp++; if (select_lines !== 2'b00) begin n_err++; $display("FAIL reset_select got %b want 00", select_lines); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_hold_valid got %b want 0", out_valid); end
        in_valid = 4'b0000;
        rst_n    = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        in_valid       = 4'b0001;
        in_data[7:0]   = 8'hA5;
        out_ready      = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL single_in_ready got %b want 0001", in_ready); end
        @(negedge clk);
        in_valid = 4'b0000;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL single_out_data got %h want a5", out_data); end
        n_cmp++; if (select_lines !== 2'b00) begin n_err++; $display("FAIL single_select got %b want 00", select_lines); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_data;
        logic [3:0] exp_ready;
        do_reset();
        in_valid  = 4'b1111;
        in_data   = 32'h13121110;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL b2b_first_ready got %b want 0001", in_ready); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
`ifdef MULTIPLEXER_ROUND_ROBIN_EN
            exp_data  = 8'h10 + 8'(k % 4);
            exp_ready = 4'b0001 << ((k + 1) % 4);
`else
            exp_data  = 8'h10;
            exp_ready = 4'b0001;
`endif
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d] got %b want 1", k, out_valid); end
            n_cmp++; if (out_data !== exp_data) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", k, out_data, exp_data); end
            n_cmp++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL b2b_ready[%0d] got %b want %b", k, in_ready, exp_ready); end
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_stall();
        do_reset();
        in_valid     = 4'b0001;
        in_data[7:0] = 8'h3C;
        out_ready    = 1'b0;
        @(negedge clk);
        in_valid       = 4'b0100;
        in_data[23:16] = 8'h77;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got %b want 1", k, out_valid); end
            n_cmp++; if (out_data !== 8'h3C) begin n_err++; $display("FAIL stall_data[%0d] got %h want 3c", k, out_data); end
            n_cmp++; if (select_lines !== 2'b00) begin n_err++; $display("FAIL stall_select[%0d] got %b want 00", k, select_lines); end
            n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL stall_ready[%0d] got %b want 0000", k, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL stall_release_ready got %b want 0100", in_ready); end
        @(negedge clk);
        in_valid = 4'b0000;
        n_cmp++; if (out_data !== 8'h77) begin n_err++; $display("FAIL stall_next_data got %h want 77", out_data); end
        n_cmp++; if (select_lines !== 2'b10) begin n_err++; $display("FAIL stall_next_select got %b want 10", select_lines); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid      = 4'b0010;
        in_data[15:8] = 8'h55;
        out_ready     = 1'b0;
        @(negedge clk);
        in_valid       = 4'b1010;
        in_data[31:24] = 8'hAA;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        n_cmp++; if (select_lines !== 2'b00) begin n_err++; $display("FAIL midrst_select got %b want 00", select_lines); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL midrst_data got %h want 00", out_data); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL midrst_ready got %b want 0000", in_ready); end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0010) begin n_err++; $display("FAIL midrst_first_ready got %b want 0010", in_ready); end
        @(negedge clk);
        in_valid = 4'b0000;
        n_cmp++; if (select_lines !== 2'b01) begin n_err++; $display("FAIL midrst_first_select got %b want 01", select_lines); end
        n_cmp++; if (out_data !== 8'h55) begin n_err++; $display("FAIL midrst_first_data got %h want 55", out_data); end
    endtask

    task automatic test_scoreboard();
        int         acc_cnt [4];
        int         out_cnt [4];
        logic [3:0] accepted;
        logic [7:0] exp_beat;
        int         c;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            acc_cnt[i] = 0;
            out_cnt[i] = 0;
        end
        for (int cyc = 0; cyc < 1010; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (cyc < 1000 && !in_valid[i] && $urandom_range(0, 1) == 1) begin
                    in_valid[i]      = 1'b1;
                    in_data[i*8 +: 8] = {i[1:0], acc_cnt[i][5:0]};
                end
            end
            out_ready = (cyc >= 1000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            n_cmp++;
            if ($countones(in_ready) > 1 || (in_ready & ~in_valid) != 4'b0000) begin
                n_err++; $display("FAIL sb_ready_onehot cyc %0d got %b valid %b", cyc, in_ready, in_valid);
            end
            if (out_valid && out_ready) begin
                c        = int'(select_lines);
                exp_beat = {select_lines, out_cnt[c][5:0]};
                n_cmp++;
                if (out_cnt[c] >= acc_cnt[c] || out_data !== exp_beat) begin
                    n_err++; $display("FAIL sb_beat cyc %0d ch %0d got %h want %h", cyc, c, out_data, exp_beat);
                end
                out_cnt[c]++;
            end
            accepted = in_valid & in_ready;
            for (int i = 0; i < 4; i++) begin
                if (accepted[i]) acc_cnt[i]++;
            end
            @(negedge clk);
            in_valid = in_valid & ~accepted;
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_cnt[i] != acc_cnt[i] || acc_cnt[i] == 0) begin
                n_err++; $display("FAIL sb_count ch %0d got %0d delivered want %0d accepted", i, out_cnt[i], acc_cnt[i]);
            end
        end
        n_cmp++; if (in_valid !== 4'b0000) begin n_err++; $display("FAIL sb_pending got %b want 0000", in_valid); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_scoreboard();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multiplexer_4_to_1_arbiter.md
MULTIPLEXER_4_TO_1_ARBITER -- requirements
Module: multiplexer_4_to_1_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every input channel and the output.
REQ-002 Port: clk  input  1  single clock; all state on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  4  per-channel valid; bit i belongs to channel i.
REQ-005 Port: in_data  input  4*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 Port: in_ready  output  4  per-channel accept strobe; a transfer on channel i occurs when in_valid[i] & in_ready[i].
REQ-007 Port: out_valid  output  1  output register holds a beat.
REQ-008 Port: out_data  output  WIDTH  registered beat data.
REQ-009 Port: out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.
REQ-010 Port: select_lines  output  2  index of the channel whose beat is in out_data.

Function
REQ-011 States: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-012 Load enable SHALL be: state EMPTY, or FULL with out_ready=1.
REQ-013 When load enabled and any in_valid set, exactly one channel SHALL be granted; in_ready is one-hot on the granted bit, else all zero.
REQ-014 in_ready SHALL be combinational from in_valid, state, out_ready and the priority pointer; it never depends on in_data.
REQ-015 On a grant, out_data/select_lines SHALL load the granted channel's data/index at the next edge and state SHALL be FULL (latency 1 cycle).
REQ-016 FULL with out_ready=1 and no in_valid SHALL go to EMPTY; FULL with out_ready=0 SHALL hold out_data/select_lines stable and in_ready=0.
REQ-017 Back-to-back grants SHALL sustain one beat per cycle while out_ready=1.
REQ-018 Arbitration (round-robin build): search starts at pointer, ascending modulo 4; after granting channel i pointer SHALL become (i+1) mod 4; pointer unchanged when no grant.
REQ-019 Arbitration (fixed build): lowest-index valid channel wins; no pointer exists.
REQ-020 A channel not granted SHALL see in_ready=0 and must keep in_valid/in_data stable; the block drops no beat and duplicates no beat.

Reset
REQ-021 rst_n low SHALL immediately force: state EMPTY, out_valid=0, out_data=0, select_lines=0, pointer=0, in_ready=0.
REQ-022 Reset asserted while FULL SHALL discard the held beat; first grant after release follows REQ-018/019 from pointer 0.

Configuration
REQ-023 Macro MULTIPLEXER_ROUND_ROBIN_EN defined: round-robin per REQ-018; undefined: fixed priority per REQ-019; all ports identical in both builds.

Structure
REQ-024 Package multiplexer_pkg SHALL hold NUM_CH=4, SEL_W=2 and the EMPTY/FULL state typedef.
REQ-025 Grant logic SHALL be one sub-module, round_robin_arbiter_4 (in: request[3:0], pointer, enable; out: one-hot grant, index), with the fixed-priority variant selected inside it by the macro.

Verification
REQ-026 Reset, in_valid=4'b0001, in_data ch0=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, select_lines=2'b00.
REQ-027 RR build, in_valid=4'b1111 held, data ch i=8'h10+i, out_ready=1 -> out_data 8'h10,8'h11,8'h12,8'h13,8'h10 on consecutive cycles.
REQ-028 Fixed build, same stimulus -> out_data 8'h10 every cycle; in_ready=4'b0001 throughout.
REQ-029 FULL with out_ready=0 for 3 cycles, in_valid=4'b0100 -> out_data/select_lines stable, in_ready=0; out_ready=1 -> ch2 granted same cycle, beat appears next cycle.
REQ-030 rst_n dropped mid-cycle while FULL -> out_valid=0 and select_lines=0 before next edge; after release, in_valid=4'b1010 -> ch1 granted first.
REQ-031 Scoreboard over 1000 random in_valid/out_ready cycles -> every accepted input beat appears exactly once, per-channel order preserved.
